// File: rtl/tart_acquire_pkg.sv
// tart_acquire_pkg: register map constants for the TART acquisition register slave
package tart_acquire_pkg;
  localparam logic [2:0] ADDR_DATA0   = 3'd0;
  localparam logic [2:0] ADDR_DATA1   = 3'd1;
  localparam logic [2:0] ADDR_DATA2   = 3'd2;
  localparam logic [2:0] ADDR_DELAY   = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;
  localparam logic [2:0] ADDR_CONTROL = 3'd7;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_DEBUG = 1;
endpackage

// File: rtl/tart_acquire.sv
// tart_acquire: 8-bit pipelined bus slave holding acquisition control and the current 24-bit sample
module tart_acquire
  import tart_acquire_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MSB   = WIDTH - 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cyc_i,
  input  logic         stb_i,
  input  logic         we_i,
  output logic         ack_o,
  input  logic [2:0]   adr_i,
  input  logic [MSB:0] dat_i,
  output logic [MSB:0] dat_o,
  input  logic         data_ready,
  output logic         data_request,
  input  logic [23:0]  data_in,
  input  logic         spi_busy,
  output logic         aq_debug_mode,
  output logic         aq_enabled,
  output logic [2:0]   aq_sample_delay
);
  logic [23:0]  sample;
  logic         valid;
  logic [MSB:0] rdata;
  logic         acc, wr, req;
  assign acc = cyc_i & stb_i;
  assign wr  = acc & we_i;
  assign req = acc & ~we_i & (adr_i == ADDR_DATA2) & aq_enabled;
  always_comb begin
    rdata = (adr_i == ADDR_DATA0)   ? sample[7:0] :
            (adr_i == ADDR_DATA1)   ? sample[15:8] :
            (adr_i == ADDR_DATA2)   ? sample[23:16] :
            (adr_i == ADDR_DELAY)   ? {5'd0, aq_sample_delay} :
            (adr_i == ADDR_STATUS)  ? {5'd0, aq_enabled, spi_busy, valid} :
            (adr_i == ADDR_CONTROL) ? {6'd0, aq_debug_mode, aq_enabled} : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o           <= 1'b0;
      dat_o           <= '0;
      data_request    <= 1'b0;
      aq_enabled      <= 1'b0;
      aq_debug_mode   <= 1'b0;
      aq_sample_delay <= 3'd0;
      sample          <= 24'd0;
      valid           <= 1'b0;
    end else begin
      ack_o        <= acc;
      data_request <= req;
      if (acc) dat_o <= rdata;
      if (wr && adr_i == ADDR_DELAY) aq_sample_delay <= dat_i[2:0];
      if (wr && adr_i == ADDR_CONTROL) begin
        aq_enabled    <= dat_i[CTRL_EN];
        aq_debug_mode <= dat_i[CTRL_DEBUG];
      end
      // a fresh sample beats a same-cycle DATA2 read, so valid stays set
      if (data_ready) begin
        sample <= data_in;
        valid  <= 1'b1;
      end else if (req) valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tart_acquire.sv
// tb_tart_acquire: directed stimulus checked against a register-map model and literal expectations
module tb_tart_acquire;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0]  adr = 3'd0;
  logic [7:0]  wdat = 8'd0;
  logic        data_ready = 1'b0;
  logic [23:0] data_in = 24'd0;
  logic        spi_busy = 1'b0;
  logic        ack, req, dbg, en;
  logic [7:0]  rdat;
  logic [2:0]  dly;
  int n_checks = 0;
  int n_fail = 0;

  tart_acquire dut (
    .clk_i(clk), .rst_ni(rst_ni), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .ack_o(ack), .adr_i(adr), .dat_i(wdat), .dat_o(rdat),
    .data_ready(data_ready), .data_request(req), .data_in(data_in),
    .spi_busy(spi_busy), .aq_debug_mode(dbg), .aq_enabled(en),
    .aq_sample_delay(dly)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: register file as the bus master sees it
  logic [23:0] m_sample = 24'd0;
  logic        m_valid = 1'b0, m_en = 1'b0, m_dbg = 1'b0;
  logic [2:0]  m_dly = 3'd0;
  logic        m_ack = 1'b0, m_rd = 1'b0, m_req = 1'b0;
  logic [7:0]  m_dat = 8'd0;

  function automatic logic [7:0] mread(input logic [2:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (a <= 3'd2) r = 8'(m_sample >> (8 * a));
    else if (a == 3'd5) r = 8'(m_dly);
    else if (a == 3'd6) r = 8'(m_valid + 2 * spi_busy + 4 * m_en);
    else if (a == 3'd7) r = 8'(m_en + 2 * m_dbg);
    return r;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_sample = 0; m_valid = 0; m_en = 0; m_dbg = 0; m_dly = 0;
      m_ack = 0; m_rd = 0; m_req = 0; m_dat = 0;
    end else begin
      m_ack = cyc && stb;
      m_rd  = m_ack && !we;
      m_req = m_rd && adr == 3'd2 && m_en;
      if (m_rd) m_dat = mread(adr);
      if (m_ack && we && adr == 3'd5) m_dly = wdat[2:0];
      if (m_ack && we && adr == 3'd7) begin m_en = wdat[0]; m_dbg = wdat[1]; end
      if (m_req) m_valid = 0;
      if (data_ready) begin m_sample = data_in; m_valid = 1; end
    end
  end

  always @(negedge clk) begin
    chk("ack", ack, m_ack);
    chk("data_request", req, m_req);
    chk("aq_enabled", en, m_en);
    chk("aq_debug_mode", dbg, m_dbg);
    chk("aq_sample_delay", dly, m_dly);
    if (m_ack && m_rd) chk("dat_o", rdat, m_dat);
  end

  // one bus cycle; returns at the negedge where its ack is visible
  task automatic xfer(input logic w, input logic [2:0] a, input logic [7:0] d);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
    xfer(0, a, 8'h00);
    chk(name, rdat, exp);
    idle();
  endtask

  task automatic capture(input logic [23:0] v);
    data_ready = 1; data_in = v;
    @(negedge clk);
    data_ready = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset ack", ack, 0);
    chk("reset dat_o", rdat, 8'h00);
    rst_ni = 1;
    @(negedge clk);
    // reset in the middle of a burst
    xfer(1, 3'd7, 8'h01);
    cyc = 1; stb = 1; we = 0; adr = 3'd0;
    @(posedge clk);
    #2 rst_ni = 0;
    #1;
    chk("midreset ack", ack, 0);
    chk("midreset en", en, 0);
    chk("midreset req", req, 0);
    idle();
    rst_ni = 1;
    @(negedge clk);
    rd(3'd6, 8'h00, "status after reset");
    // enable
    xfer(1, 3'd7, 8'h01);
    chk("write ack", ack, 1);
    chk("enable set", en, 1);
    idle();
    rd(3'd7, 8'h01, "control rd");
    rd(3'd6, 8'h04, "status en");
    // sample capture and burst read with acquisition enabled
    capture(24'hA5C33C);
    rd(3'd6, 8'h05, "status valid");
    xfer(0, 3'd0, 0); chk("data0", rdat, 8'h3C); chk("req d0", req, 0);
    xfer(0, 3'd1, 0); chk("data1", rdat, 8'hC3); chk("req d1", req, 0);
    xfer(0, 3'd2, 0); chk("data2", rdat, 8'hA5); chk("req d2", req, 1);
    idle();
    chk("req one cycle", req, 0);
    rd(3'd6, 8'h04, "status cleared");
    // same with acquisition disabled
    xfer(1, 3'd7, 8'h00); idle();
    capture(24'hA5C33C);
    xfer(0, 3'd0, 0); chk("dis data0", rdat, 8'h3C);
    xfer(0, 3'd1, 0); chk("dis data1", rdat, 8'hC3);
    xfer(0, 3'd2, 0); chk("dis data2", rdat, 8'hA5); chk("dis req", req, 0);
    idle();
    chk("dis req after", req, 0);
    rd(3'd6, 8'h01, "status dis valid kept");
    // delay and debug
    xfer(1, 3'd5, 8'hFF); idle();
    chk("delay", dly, 3'b111);
    rd(3'd5, 8'h07, "delay rd");
    xfer(1, 3'd7, 8'h02); idle();
    chk("debug", dbg, 1);
    chk("debug en", en, 0);
    rd(3'd7, 8'h02, "control dbg");
    // reserved and read-only addresses ignore writes
    xfer(1, 3'd3, 8'hAA); xfer(1, 3'd6, 8'hFF); xfer(1, 3'd0, 8'h11); idle();
    rd(3'd3, 8'h00, "reserved");
    rd(3'd4, 8'h00, "reserved4");
    rd(3'd0, 8'h3C, "ro data0");
    // capture colliding with a DATA2 read
    xfer(1, 3'd7, 8'h01); idle();
    data_ready = 1; data_in = 24'h123456;
    xfer(0, 3'd2, 0);
    data_ready = 0;
    chk("collide ack", ack, 1);
    chk("collide data2", rdat, 8'hA5);
    chk("collide req", req, 1);
    idle();
    spi_busy = 1;
    rd(3'd6, 8'h07, "collide status");
    spi_busy = 0;
    rd(3'd0, 8'h56, "collide data0");
    rd(3'd2, 8'h12, "new data2");
    rd(3'd6, 8'h04, "final status");
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
